// File: rtl/lab_hold_scheduler.sv
// lab_hold_scheduler: tracks the four LAB buffers, queues HOLD events in arrival order and runs one digitize at a time.
// Optional build define LAB_HOLD_SCHED_SOFT_HOLD_EN adds soft_hold_i, a clk_i-domain HOLD injection port.
module lab_hold_scheduler #(
  parameter int NUM_BUF     = 4,
  parameter int DIG_TIMEOUT = 4095,
  parameter int CNT_W       = 16
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  input  logic [NUM_BUF-1:0] hold_i,
  input  logic               done_i,
  input  logic [NUM_BUF-1:0] release_i,
`ifdef LAB_HOLD_SCHED_SOFT_HOLD_EN
  input  logic [NUM_BUF-1:0] soft_hold_i,
`endif
  output logic [NUM_BUF-1:0] digitize_o,
  output logic               busy_o,
  output logic [NUM_BUF-1:0] full_o,
  output logic [NUM_BUF-1:0] pending_o,
  output logic               timeout_o,
  output logic [CNT_W-1:0]   evt_cnt_o,
  output logic [CNT_W-1:0]   drop_cnt_o
);

  localparam int               IDX_W    = 2;
  localparam int               TMR_W    = $clog2(DIG_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DIG_TIMEOUT - 1);
  localparam logic [2:0]       Q_DEPTH  = 3'(NUM_BUF);

  typedef enum logic [1:0] {
    BUF_FREE = 2'd0,
    BUF_HELD = 2'd1,
    BUF_DIG  = 2'd2,
    BUF_FULL = 2'd3
  } buf_state_e;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } fsm_state_e;

  logic [NUM_BUF-1:0] sync1_r, sync2_r, prev_r;
  logic [NUM_BUF-1:0] edge_s, evt_s, acc_s, drop_s, notfree_s;
  buf_state_e         buf_r     [NUM_BUF];
  buf_state_e         buf_nxt_s [NUM_BUF];
  logic [IDX_W-1:0]   q_r       [NUM_BUF];
  logic [IDX_W-1:0]   q_nxt_s   [NUM_BUF];
  logic [2:0]         q_cnt_r, q_cnt_s;
  fsm_state_e         fsm_r, fsm_nxt_s;
  logic [IDX_W-1:0]   active_r, active_nxt_s;
  logic [NUM_BUF-1:0] dig_r, dig_nxt_s;
  logic [TMR_W-1:0]   timer_r, timer_nxt_s;
  logic               timeout_r, timeout_nxt_s, pop_s;
  logic [NUM_BUF-1:0] full_r, pending_r;
  logic               busy_r;
  logic [CNT_W-1:0]   evt_cnt_r, drop_cnt_r;

  function automatic logic [2:0] popcnt(input logic [NUM_BUF-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_BUF; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-2){1'b0}}, n};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Two-flop synchroniser plus rising-edge history for the asynchronous HOLD lines
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      sync1_r <= '0;
      sync2_r <= '0;
      prev_r  <= '0;
    end else begin
      sync1_r <= hold_i;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign edge_s = sync2_r & ~prev_r;
`ifdef LAB_HOLD_SCHED_SOFT_HOLD_EN
  assign evt_s = edge_s | soft_hold_i;
`else
  assign evt_s = edge_s;
`endif

  // Buffer bookkeeping, order queue and scheduler next-state
  always_comb begin
    buf_nxt_s     = buf_r;
    q_nxt_s       = q_r;
    q_cnt_s       = q_cnt_r;
    fsm_nxt_s     = fsm_r;
    active_nxt_s  = active_r;
    dig_nxt_s     = dig_r;
    timer_nxt_s   = timer_r;
    timeout_nxt_s = timeout_r;
    acc_s         = '0;
    drop_s        = '0;
    notfree_s     = '0;
    pop_s         = 1'b0;

    // release is applied before the HOLD event so a same-cycle collision is accepted
    for (int k = 0; k < NUM_BUF; k++) begin
      if (release_i[k] && (buf_r[k] == BUF_FULL)) begin
        buf_nxt_s[k] = BUF_FREE;
      end else begin
        buf_nxt_s[k] = buf_r[k];
      end
      acc_s[k]     = evt_s[k] && (buf_nxt_s[k] == BUF_FREE);
      drop_s[k]    = evt_s[k] && (buf_nxt_s[k] != BUF_FREE);
      buf_nxt_s[k] = acc_s[k] ? BUF_HELD : buf_nxt_s[k];
    end

    case (fsm_r)
      S_IDLE: begin
        if (q_cnt_r != 3'd0) begin
          pop_s               = 1'b1;
          active_nxt_s        = q_r[0];
          buf_nxt_s[q_r[0]]   = BUF_DIG;
          dig_nxt_s           = {{(NUM_BUF-1){1'b0}}, 1'b1} << q_r[0];
          fsm_nxt_s           = S_ISSUE;
        end else begin
          fsm_nxt_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        timer_nxt_s = '0;
        fsm_nxt_s   = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (done_i) begin
          dig_nxt_s           = '0;
          buf_nxt_s[active_r] = BUF_FULL;
          fsm_nxt_s           = S_GAP;
        end else if (timer_r == TMR_LAST) begin
          dig_nxt_s           = '0;
          timeout_nxt_s       = 1'b1;
          buf_nxt_s[active_r] = BUF_FREE;
          fsm_nxt_s           = S_GAP;
        end else begin
          timer_nxt_s = timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
        end
      end
      S_GAP: begin
        if (!done_i) begin
          fsm_nxt_s = S_IDLE;
        end else begin
          fsm_nxt_s = S_GAP;
        end
      end
      default: begin
        fsm_nxt_s = S_IDLE;
        dig_nxt_s = '0;
      end
    endcase

    if (pop_s) begin
      for (int i = 0; i < NUM_BUF - 1; i++) begin
        q_nxt_s[i] = q_r[i+1];
      end
      q_cnt_s = q_cnt_r - 3'd1;
    end else begin
      q_cnt_s = q_cnt_r;
    end

    // ascending loop order gives the required multi-push ordering
    for (int k = 0; k < NUM_BUF; k++) begin
      if (acc_s[k] && (q_cnt_s < Q_DEPTH)) begin
        q_nxt_s[q_cnt_s[IDX_W-1:0]] = IDX_W'(k);
        q_cnt_s                     = q_cnt_s + 3'd1;
      end else begin
        q_cnt_s = q_cnt_s;
      end
      notfree_s[k] = (buf_nxt_s[k] != BUF_FREE);
    end
  end

  // Buffer, queue and scheduler state registers
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int k = 0; k < NUM_BUF; k++) begin
        buf_r[k] <= BUF_FREE;
        q_r[k]   <= '0;
      end
      q_cnt_r   <= 3'd0;
      fsm_r     <= S_IDLE;
      active_r  <= '0;
      dig_r     <= '0;
      timer_r   <= '0;
      timeout_r <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_BUF; k++) begin
        buf_r[k] <= buf_nxt_s[k];
        q_r[k]   <= q_nxt_s[k];
      end
      q_cnt_r   <= q_cnt_s;
      fsm_r     <= fsm_nxt_s;
      active_r  <= active_nxt_s;
      dig_r     <= dig_nxt_s;
      timer_r   <= timer_nxt_s;
      timeout_r <= timeout_nxt_s;
    end
  end

  // Registered status flags and saturating event counters
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      full_r     <= '0;
      pending_r  <= '0;
      busy_r     <= 1'b0;
      evt_cnt_r  <= '0;
      drop_cnt_r <= '0;
    end else begin
      for (int k = 0; k < NUM_BUF; k++) begin
        full_r[k]    <= (buf_nxt_s[k] == BUF_FULL);
        pending_r[k] <= (buf_nxt_s[k] == BUF_HELD);
      end
      busy_r     <= &notfree_s;
      evt_cnt_r  <= sat_add(evt_cnt_r, popcnt(acc_s));
      drop_cnt_r <= sat_add(drop_cnt_r, popcnt(drop_s));
    end
  end

  assign digitize_o = dig_r;
  assign busy_o     = busy_r;
  assign full_o     = full_r;
  assign pending_o  = pending_r;
  assign timeout_o  = timeout_r;
  assign evt_cnt_o  = evt_cnt_r;
  assign drop_cnt_o = drop_cnt_r;

endmodule
